// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the radix-2 FFT controller.
package fft_pkg;

  localparam int LOG2N_DEF = 4;
  localparam int N_DEF     = 1 << LOG2N_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Width of the stage counter for a given log2 size (at least one bit).
  function automatic int stage_w(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// In-place DIT operand/twiddle address generator; purely combinational.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic [stage_w(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]          k,
  output logic [LOG2N-1:0]          addr_a,
  output logic [LOG2N-1:0]          addr_b,
  output logic [LOG2N-2:0]          tw_addr
);

  localparam int KW = LOG2N - 1;

  logic [KW-1:0]    w_mask;
  logic [KW-1:0]    w_pos;
  logic [KW-1:0]    w_grp;
  logic [LOG2N-1:0] w_a;

  // On the last stage span = N/2 overflows KW bits; 0 - 1 then yields the all-ones mask we want.
  assign w_mask  = (KW'(1) << s) - KW'(1);
  assign w_pos   = k & w_mask;
  assign w_grp   = k >> s;
  assign w_a     = ({w_grp, 1'b0} << s) | {1'b0, w_pos};
  assign addr_a  = w_a;
  assign addr_b  = w_a | (LOG2N'(1) << s);
  assign tw_addr = w_pos << (KW - int'(s));

endmodule

// File: rtl/fft_ra2_ctrl.sv
// Sequencer for an in-place radix-2 FFT: issues LOG2N*N/2 butterflies to a serial
// butterfly unit, one at a time, with registered RAM/ROM addresses and a WAIT timeout.
module fft_ra2_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int TMO   = 255
) (
  input  logic             rst_n,
  input  logic             clk,
  input  logic             start,
  output logic             bf_go,
  input  logic             bf_done,
  input  logic             bf_wren,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             ram_we,
  output logic             busy,
  output logic             fft_done,
  output logic             err
);

  localparam int                SW     = stage_w(LOG2N);
  localparam int                KW     = LOG2N - 1;
  localparam int                TW     = $clog2(TMO + 1);
  localparam logic [SW-1:0]     S_LAST = SW'(LOG2N - 1);
  localparam logic [KW-1:0]     K_LAST = '1;
  localparam logic [TW-1:0]     T_LAST = TW'(TMO - 1);

  state_t           r_state;
  logic [SW-1:0]    r_s;
  logic [KW-1:0]    r_k;
  logic [TW-1:0]    r_tmo;
  logic             r_bf_go;
  logic             r_busy;
  logic             r_fft_done;
  logic             r_err;
  logic [LOG2N-1:0] r_addr_a;
  logic [LOG2N-1:0] r_addr_b;
  logic [KW-1:0]    r_tw_addr;

  logic             w_k_wrap;
  logic             w_last;
  logic             w_issue;
  logic [SW-1:0]    w_s_nxt;
  logic [KW-1:0]    w_k_nxt;
  logic [LOG2N-1:0] w_addr_a;
  logic [LOG2N-1:0] w_addr_b;
  logic [KW-1:0]    w_tw_addr;

  assign w_k_wrap = (r_k == K_LAST);
  assign w_last   = w_k_wrap && (r_s == S_LAST);

  // Next butterfly coordinates: advance from WAIT, restart at (0,0) from IDLE/ERR.
  assign w_s_nxt  = (r_state == ST_WAIT) ? (w_k_wrap ? r_s + SW'(1) : r_s) : '0;
  assign w_k_nxt  = (r_state == ST_WAIT) ? r_k + KW'(1) : '0;

  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR: w_issue = start;
      ST_WAIT:         w_issue = bf_done && !w_last;
      default:         w_issue = 1'b0;
    endcase
  end

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s       (w_s_nxt),
    .k       (w_k_nxt),
    .addr_a  (w_addr_a),
    .addr_b  (w_addr_b),
    .tw_addr (w_tw_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_s        <= '0;
      r_k        <= '0;
      r_tmo      <= '0;
      r_bf_go    <= 1'b0;
      r_busy     <= 1'b0;
      r_fft_done <= 1'b0;
      r_err      <= 1'b0;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      r_tw_addr  <= '0;
    end else begin
      r_bf_go    <= 1'b0;
      r_fft_done <= 1'b0;
      if (w_issue) begin
        r_state   <= ST_ISSUE;
        r_s       <= w_s_nxt;
        r_k       <= w_k_nxt;
        r_addr_a  <= w_addr_a;
        r_addr_b  <= w_addr_b;
        r_tw_addr <= w_tw_addr;
        r_bf_go   <= 1'b1;
        r_busy    <= 1'b1;
        r_err     <= 1'b0;
      end else begin
        case (r_state)
          ST_ISSUE: begin
            r_state <= ST_WAIT;
            r_tmo   <= '0;
          end
          ST_WAIT: begin
            if (bf_done) begin
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_fft_done <= 1'b1;
            end else if (r_tmo == T_LAST) begin
              r_state <= ST_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          ST_IDLE, ST_ERR: r_state <= r_state;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bf_go    = r_bf_go;
  assign busy     = r_busy;
  assign fft_done = r_fft_done;
  assign err      = r_err;
  assign addr_a   = r_addr_a;
  assign addr_b   = r_addr_b;
  assign tw_addr  = r_tw_addr;
  // r_busy is high exactly in ISSUE and WAIT, so the write strobe passes straight through then.
  assign ram_we   = bf_wren & r_busy;

endmodule
